// File: rtl/ddr_bw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : ddr_bw_pkg                                                      |
// | Purpose   : Shared types and default widths for the DDR read-bandwidth      |
// |             meter (FSM state encoding, counter/window/beat-size defaults). |
// | Contents  : state_t    - IDLE/RUN/DONE encoding of the measurement FSM      |
// |             DEF_*      - default widths used as parameter defaults         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package ddr_bw_pkg;

  // Measurement FSM encoding. Values are fixed so that a state captured by an
  // external debug tap decodes the same way across builds.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default datapath widths.
  localparam int DEF_WIN_W     = 32;  // window length / elapsed-cycle counter
  localparam int DEF_CNT_W     = 32;  // R-beat counter
  localparam int DEF_BEAT_LOG2 = 3;   // log2(bytes per R beat): 8-byte beats
  localparam int DEF_LAT_W     = 16;  // first-beat latency counter

  // Number of control/strobe bits carried through the input delay line:
  // {start, abort, ar_hs, r_hs}.
  localparam int PIPE_W = 4;

endpackage : ddr_bw_pkg
`default_nettype wire

// File: rtl/latency_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : latency_pipe                                                    |
// | Purpose   : DEPTH-deep shift register with synchronous active-high reset.  |
// |             Used to delay the meter's control pulses and AXI handshake      |
// |             strobes as one bundle so they stay cycle-aligned.              |
// |             DEPTH = 0 gives a combinational bypass.                        |
// | Ports     : clk  in  1      clock                                          |
// |             rst  in  1      synchronous reset, clears every stage          |
// |             din  in  WIDTH  bundle entering the delay line                 |
// |             dout out WIDTH  bundle delayed by DEPTH cycles                 |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module latency_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // No registers: clock and reset are intentionally left unused.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule : latency_pipe
`default_nettype wire

// File: rtl/ddr_bw_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : ddr_bw_meter                                                    |
// | Purpose   : Measures DDR read-path throughput over a programmable window   |
// |             of clk cycles. Counts R-channel handshakes, derives the byte   |
// |             count and reports elapsed cycles to the bandwidth-test regs.   |
// |             Optional first-beat latency measurement (AR hs -> R hs) is     |
// |             built only when the macro LAT_MEAS_EN is defined; otherwise    |
// |             lat_first/lat_vld are tied to 0.                               |
// | Ports     : clk, rst             clock, synchronous active-high reset       |
// |             start, abort         1-cycle control pulses                     |
// |             win_len   [WIN_W]    window length, sampled at delayed start    |
// |             ar_vld/ar_rdy        AR channel handshake                       |
// |             r_vld/r_rdy          R channel handshake                        |
// |             busy                 window active (RUN)                        |
// |             done                 1-cycle pulse, results final               |
// |             beats     [CNT_W]    R handshakes in window (saturating)        |
// |             bytes     [CNT_W+BEAT_LOG2] beats << BEAT_LOG2                  |
// |             cycles    [WIN_W]    cycles elapsed in window                   |
// |             sat                  beat counter saturated                     |
// |             lat_first [LAT_W]    first AR hs -> first R hs latency          |
// |             lat_vld              lat_first valid                            |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module ddr_bw_meter
  import ddr_bw_pkg::*;
#(
  parameter int IN_LAT    = 2,
  parameter int WIN_W     = DEF_WIN_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BEAT_LOG2 = DEF_BEAT_LOG2,
  parameter int LAT_W     = DEF_LAT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIN_W-1:0]           win_len,
  input  logic                       ar_vld,
  input  logic                       ar_rdy,
  input  logic                       r_vld,
  input  logic                       r_rdy,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           beats,
  output logic [CNT_W+BEAT_LOG2-1:0] bytes,
  output logic [WIN_W-1:0]           cycles,
  output logic                       sat,
  output logic [LAT_W-1:0]           lat_first,
  output logic                       lat_vld
);

  // --------------------------------------------------------------------------
  // Input delay line: control pulses and handshake strobes travel together so
  // that a strobe seen on the same input cycle as start/abort is judged
  // against the same FSM state after the delay.
  // --------------------------------------------------------------------------
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  logic              start_d;
  logic              abort_d;
  logic              ar_hs_d;
  logic              r_hs_d;

  assign pipe_in = {start, abort, ar_vld & ar_rdy, r_vld & r_rdy};

  latency_pipe #(
    .DEPTH (IN_LAT),
    .WIDTH (PIPE_W)
  ) u_in_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign {start_d, abort_d, ar_hs_d, r_hs_d} = pipe_out;

  // --------------------------------------------------------------------------
  // Measurement FSM
  // --------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] cycles_q;
  logic [CNT_W-1:0] beats_q;
  logic             sat_q;
  logic             accept_start;
  logic             run_step;
  logic             last_cycle;

  // A start is only honoured from IDLE; in RUN/DONE it is dropped.
  assign accept_start = (state == ST_IDLE) && start_d;

  // Abort wins over counting and over end-of-window: the aborted cycle is not
  // counted, so partial results reflect only whole cycles before the abort.
  assign run_step   = (state == ST_RUN) && !abort_d;

  // win_q is never 0 while in RUN, so win_q-1 cannot wrap here.
  assign last_cycle = (cycles_q == (win_q - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_d) begin
          state_nxt = (win_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort_d) begin
          state_nxt = ST_IDLE;
        end else if (last_cycle) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Window / beat counters. Results are held in IDLE and DONE and only cleared
  // by an accepted start (or reset).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      cycles_q <= '0;
      beats_q  <= '0;
      sat_q    <= 1'b0;
    end else if (accept_start) begin
      win_q    <= win_len;
      cycles_q <= '0;
      beats_q  <= '0;
      sat_q    <= 1'b0;
    end else if (run_step) begin
      // Bounded by win_q, so no overflow check is needed.
      cycles_q <= cycles_q + 1'b1;
      if (r_hs_d) begin
        // sat flags a beat that could not be counted; the counter pins at
        // all-ones from then on.
        if (beats_q == '1) begin
          sat_q <= 1'b1;
        end else begin
          beats_q <= beats_q + 1'b1;
        end
      end
    end
  end

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign beats  = beats_q;
  assign cycles = cycles_q;
  assign sat    = sat_q;
  assign bytes  = (CNT_W+BEAT_LOG2)'(beats_q) << BEAT_LOG2;

  // --------------------------------------------------------------------------
  // First-beat latency (optional)
  // --------------------------------------------------------------------------
`ifdef LAT_MEAS_EN
  logic             lat_armed;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_first_q;
  logic             lat_vld_q;

  // The counter is loaded with 1 on the arming cycle so that an R handshake
  // N cycles after the AR handshake freezes exactly N. An R handshake on the
  // arming cycle itself is not considered: arming has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_armed   <= 1'b0;
      lat_cnt     <= '0;
      lat_first_q <= '0;
      lat_vld_q   <= 1'b0;
    end else if (accept_start) begin
      lat_armed   <= 1'b0;
      lat_cnt     <= '0;
      lat_first_q <= '0;
      lat_vld_q   <= 1'b0;
    end else if (run_step) begin
      if (!lat_armed) begin
        if (ar_hs_d) begin
          lat_armed <= 1'b1;
          lat_cnt   <= LAT_W'(1);
        end
      end else if (!lat_vld_q) begin
        if (r_hs_d) begin
          lat_first_q <= lat_cnt;
          lat_vld_q   <= 1'b1;
        end else if (lat_cnt != '1) begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
    end
  end

  assign lat_first = lat_first_q;
  assign lat_vld   = lat_vld_q;
`else
  // Latency measurement not built; the AR strobe has no consumer.
  logic unused_ar_hs;
  assign unused_ar_hs = ar_hs_d;

  assign lat_first = '0;
  assign lat_vld   = 1'b0;
`endif

endmodule : ddr_bw_meter
`default_nettype wire
